// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared shift-add multiply / restoring divide datapath, one iteration per step.
// Divide mode keeps the remainder in the high word and the quotient in the low word.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q, acc_next;
  logic [XLEN-1:0]   opb_q, acc_hi, acc_lo;
  logic [XLEN:0]     add_sum, shifted, diff;

  assign acc_hi = acc_q[2*XLEN-1:XLEN];
  assign acc_lo = acc_q[XLEN-1:0];
  assign acc    = acc_q;

  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    shifted = {acc_hi, acc_lo[XLEN-1]};
    diff    = shifted - {1'b0, opb_q};
    if (!is_div)
      acc_next = {add_sum, acc_lo[XLEN-1:1]};
    else if (diff[XLEN])  // borrow: restore the shifted remainder
      acc_next = {shifted[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
    else
      acc_next = {diff[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
    end else if (load) begin
      acc_q <= {{XLEN{1'b0}}, mag_a};
      opb_q <= mag_b;
    end else if (step) begin
      acc_q <= acc_next;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle M-extension sequencer: operand latch, special divide cases, FSM, sign fixup.
//   state | meaning
//   IDLE  | waiting for mul_en/div_en; latches operands on start
//   RUN   | one datapath iteration per cycle, XLEN cycles
//   FIXUP | apply signs, select word, register result
//   DONE  | one-cycle done strobe, requests ignored
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mul_en,
  input  logic            div_en,
  input  logic [2:0]      funct3,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              is_div_q, sign_a_q, sign_b_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   result_q;
  logic              start, load, step;
  logic              a_signed, b_signed, sign_a, sign_b;
  logic              div_zero, div_ovf, special, rem_sel;
  logic [XLEN-1:0]   mag_a, mag_b, special_res, fix_res;
  logic [XLEN-1:0]   quot, rem, quot_fix, rem_fix;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign start  = (mul_en | div_en) & ~flush;
  assign result = result_q;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    sign_a   = a_signed & op_a[XLEN-1];
    sign_b   = b_signed & op_b[XLEN-1];
    mag_a    = sign_a ? -op_a : op_a;
    mag_b    = sign_b ? -op_b : op_b;
    rem_sel  = (funct3 == F3_REM) | (funct3 == F3_REMU);
    div_zero = (op_b == '0);
    div_ovf  = ((funct3 == F3_DIV) | (funct3 == F3_REM)) & (op_a == INT_MIN) & (op_b == '1);
    special  = div_en & (div_zero | div_ovf);
    if (div_zero)
      special_res = rem_sel ? op_a : '1;
    else
      special_res = rem_sel ? '0 : INT_MIN;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = special ? DONE : RUN;
      RUN:     if (cnt_q == '0) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    load = 1'b0;
    step = 1'b0;
    case (state_q)
      IDLE: begin
        busy = start;
        load = start & ~special;
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
      end
      FIXUP:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
    if (flush | rst) busy = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      f3_q     <= '0;
      result_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        cnt_q    <= CNT_LAST;
        is_div_q <= div_en;
        f3_q     <= funct3;
        sign_a_q <= sign_a;
        sign_b_q <= sign_b;
        if (special) result_q <= special_res;
      end else if (state_q == RUN && cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (state_q == FIXUP && !flush) result_q <= fix_res;
    end
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (is_div_q),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .acc    (prod)
  );

  // Remainder sits in the high word, quotient in the low word after a divide.
  assign quot = prod[XLEN-1:0];
  assign rem  = prod[2*XLEN-1:XLEN];

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quot_fix = (sign_a_q ^ sign_b_q) ? -quot : quot;
    rem_fix  = sign_a_q ? -rem : rem;
    case (f3_q)
      F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the M-extension multiply/divide resource in the execute stage. It accepts the `mul_en`/`div_en` request produced by the main decoder and runs an iterative shift-add multiply or restoring divide on latched operands. It stalls the pipeline through `busy` and returns a one-cycle `done` strobe with the result. All multiply and divide instructions share one iterative datapath; at most one operation is in flight.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (iteration count = XLEN)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mul_en`  in  1  EX-stage multiply request; held high while stalled
- `div_en`  in  1  EX-stage divide request; held high while stalled
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `flush`  in  1  abort current op (branch/jump redirect)
- `op_a`  in  XLEN  rs1 operand
- `op_b`  in  XLEN  rs2 operand
- `busy`  out  1  combinational stall request to hazard unit
- `done`  out  1  registered one-cycle result-valid strobe
- `result`  out  XLEN  registered result, valid when `done`=1

## Operation
- States: IDLE, RUN, FIXUP, DONE.
- **IDLE**
  - `start` = (`mul_en` | `div_en`) & ~`flush`.
  - On `start`, latch the magnitudes of `op_a`/`op_b`, the operand signs, `funct3`, and the op class. `div_en` has priority if both are high.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU/DIVU/REMU treat both as unsigned.
  - Special divide cases go straight to DONE:
    - divisor = 0: quotient = all-ones, remainder = `op_a`.
    - DIV/REM with a = 0x80000000 and b = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Otherwise load the counter with XLEN-1 and go to RUN.
- **RUN**: one iteration per cycle.
  - Multiply: 2·XLEN-bit accumulator; add the multiplicand when the multiplier LSB is 1, then shift right.
  - Divide: restoring; shift the remainder left, subtract the divisor, keep the result if non-negative, and shift the quotient bit in.
  - Counter decrements; at 0 go to FIXUP.
- **FIXUP**
  - Product: negate if sign_a XOR sign_b (signed forms only).
  - Quotient: negate if the signs differ.
  - Remainder: takes the sign of the dividend.
  - Select the low/high product word, or the quotient/remainder. Register `result`, go to DONE.
- **DONE**: `done`=1, `busy`=0, pipeline advances. Requests are ignored this cycle; next state is IDLE.
- `busy` = (state==IDLE & `start`) | state==RUN | state==FIXUP.
- **Flush**: in any state, next state is IDLE, no `done`, `result` unchanged, `busy` deasserted the same cycle.
- **Reset**: state IDLE, `done`=0, `result`=0, counter 0. `busy`=0 while `rst`=1. Reset mid-operation discards the operation.

## Timing
- Request first seen in IDLE at cycle t; the same cycle raises `busy`.
- Normal path:
  - cycles t+1..t+XLEN: RUN
  - t+XLEN+1: FIXUP
  - t+XLEN+2: DONE
- `busy` is high for exactly XLEN+2 cycles (t..t+XLEN+1).
- Special divide: DONE at t+1, `busy` high for cycle t only.
- Back-to-back: a new request can start at the cycle after DONE (the next instruction reaches EX).
- `flush` has priority over a request in the same cycle.
- Widths: intermediates are 2·XLEN for multiply and XLEN+1 for the divide remainder/subtract. Negation is two's complement modulo 2^XLEN (negating 0x80000000 yields 0x80000000).

## Structure
- Package `muldiv_pkg`:
  - `state_t` enum {IDLE, RUN, FIXUP, DONE}
  - funct3 localparams `F3_MUL`..`F3_REMU`
  - `XLEN` default
- One sub-module, `muldiv_iter_core`: holds the accumulator/remainder/quotient registers and performs one iteration per `step` pulse. The FSM, special-case detection, and sign fixup stay in `muldiv_sequencer`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `result` 0xFFFFFFEB, `done` at t+34, `busy` high for 34 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH on the same operands → 0x00000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF with `done` at t+1; REM 0x1234/0 → 0x1234; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Start DIV, assert `flush` at t+10 → no `done`, `busy` low from t+10. New MUL 3×4 at t+11 → 12 at t+45. Same sequence with `rst` instead of `flush` → identical behaviour.
- Hold `mul_en` high through DONE and one cycle after with new operands 2×5 → exactly two `done` strobes, results 12 then 10, no third start.
